// File: rtl/core_mem_pkg.sv
// core_mem_pkg: shared types and helpers for the multi-core DDR3 request
// controller.
//   state_t       - controller FSM states
//   CMD_WRITE/READ - MIG UI app_cmd encodings
//   lane_width()  - bits needed to index a word lane inside an app beat
//   offset_width()- byte-offset bits inside one core word
//   beat_lsb()    - app_addr bits that address inside one app beat
package core_mem_pkg;

  typedef enum logic [2:0] {
    ST_CALIB,
    ST_ARB,
    ST_READ_CMD,
    ST_READ_WAIT,
    ST_WRITE,
    ST_RESP
  } state_t;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // At least one bit so a lane index signal always exists, even with one lane.
  function automatic int lane_width(input int app_w, input int word_w);
    return ((app_w / word_w) > 1) ? $clog2(app_w / word_w) : 1;
  endfunction

  function automatic int offset_width(input int word_w);
    return $clog2(word_w / 8);
  endfunction

  // app_addr counts 16-bit DQ columns, so one beat spans app_w/16 columns.
  function automatic int beat_lsb(input int app_w);
    return $clog2(app_w / 16);
  endfunction

endpackage

// File: rtl/core_mem_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin request selector.
//   clk, reset   - UI clock, synchronous active-high reset
//   req          - per-core request vector
//   last_grant   - id of the core just served, loaded into the pointer
//   enable       - load strobe for the pointer
//   grant_id     - winning core (combinational)
//   grant_valid  - at least one request is pending (combinational)
// Search starts one past the pointer, so the last served core has the
// lowest priority. After reset the pointer sits at NUM_CORES-1, giving
// core 0 first priority.
module rr_arbiter #(
  parameter int NUM_CORES = 16,
  parameter int ID_W      = $clog2(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] req,
  input  logic [ID_W-1:0]      last_grant,
  input  logic                 enable,
  output logic [ID_W-1:0]      grant_id,
  output logic                 grant_valid
);

  logic [ID_W-1:0] ptr_reg;
  int              idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= ID_W'(NUM_CORES - 1);
    end else if (enable) begin
      ptr_reg <= last_grant;
    end
  end

  // Walk from the farthest offset down to the nearest so the nearest
  // requesting core after the pointer overwrites any earlier candidate.
  always_comb begin
    grant_id    = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = NUM_CORES; k >= 1; k--) begin
      idx = (int'(ptr_reg) + k) % NUM_CORES;
      if (req[idx]) begin
        grant_id    = ID_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_mem_ctrl.sv
// core_mem_ctrl: arbitrates NUM_CORES word-sized requests onto the MIG UI
// application port (ui_clk domain).
//   clk, reset            - ui_clk and ui_clk_sync_rst (sync, active-high)
//   init_calib_complete   - start serving once calibration is done
//   core_req_*            - per-core valid/wr/byte address/write word
//   core_resp_valid/rdata - one-hot completion pulse and read word
//   app_*                 - MIG UI command, write-data and read-data ports
// All outputs are registered. Reads pick one word lane out of the returned
// beat; writes replicate the word across the beat and unmask only its lane.
module core_mem_ctrl
  import core_mem_pkg::*;
#(
  parameter int NUM_CORES      = 16,
  parameter int WORD_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 28,
  parameter int APP_DATA_WIDTH = 128
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          init_calib_complete,
  input  logic [NUM_CORES-1:0]          core_req_valid,
  input  logic [NUM_CORES-1:0]          core_req_wr,
  input  logic [NUM_CORES*32-1:0]       core_req_addr,
  input  logic [NUM_CORES*WORD_WIDTH-1:0] core_req_wdata,
  output logic [NUM_CORES-1:0]          core_resp_valid,
  output logic [WORD_WIDTH-1:0]         core_resp_rdata,
  output logic [ADDR_WIDTH-1:0]         app_addr,
  output logic [2:0]                    app_cmd,
  output logic                          app_en,
  input  logic                          app_rdy,
  output logic [APP_DATA_WIDTH-1:0]     app_wdf_data,
  output logic [APP_DATA_WIDTH/8-1:0]   app_wdf_mask,
  output logic                          app_wdf_wren,
  output logic                          app_wdf_end,
  input  logic                          app_wdf_rdy,
  input  logic [APP_DATA_WIDTH-1:0]     app_rd_data,
  input  logic                          app_rd_data_valid
);

  localparam int LANES    = APP_DATA_WIDTH / WORD_WIDTH;
  localparam int ID_W     = $clog2(NUM_CORES);
  localparam int LANE_W   = lane_width(APP_DATA_WIDTH, WORD_WIDTH);
  localparam int OFF_W    = offset_width(WORD_WIDTH);
  localparam int BEAT_LSB = beat_lsb(APP_DATA_WIDTH);
  localparam int BPW      = WORD_WIDTH / 8;
  localparam int MASK_W   = APP_DATA_WIDTH / 8;

  // Per-core views of the flattened request buses.
  logic [31:0]           req_addr  [NUM_CORES];
  logic [WORD_WIDTH-1:0] req_wdata [NUM_CORES];

  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_unpack
      assign req_addr[gi]  = core_req_addr[gi*32 +: 32];
      assign req_wdata[gi] = core_req_wdata[gi*WORD_WIDTH +: WORD_WIDTH];
    end
  endgenerate

  state_t          state_reg;
  logic [ID_W-1:0] id_reg;
  logic [LANE_W-1:0] lane_reg;

  logic [ID_W-1:0] grant_id;
  logic            grant_valid;

  rr_arbiter #(
    .NUM_CORES (NUM_CORES),
    .ID_W      (ID_W)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (core_req_valid),
    .last_grant  (id_reg),
    .enable      (state_reg == ST_RESP),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  // Address decode of the current arbitration winner.
  logic [31:0]           sel_addr;
  logic [ADDR_WIDTH-1:0] sel_app_addr;
  logic [LANE_W-1:0]     sel_lane;
  logic [MASK_W-1:0]     sel_mask;

  always_comb begin
    sel_addr     = req_addr[grant_id];
    // Byte address -> 16-bit column address, aligned to the start of the beat.
    sel_app_addr = ADDR_WIDTH'(sel_addr >> 1);
    sel_app_addr[BEAT_LSB-1:0] = '0;
    sel_lane     = LANE_W'((sel_addr >> OFF_W) % LANES);
    sel_mask     = '1;
    sel_mask[sel_lane*BPW +: BPW] = '0;
  end

  logic [NUM_CORES-1:0] id_onehot;
  assign id_onehot = {{(NUM_CORES-1){1'b0}}, 1'b1} << id_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_CALIB;
      id_reg          <= '0;
      lane_reg        <= '0;
      app_en          <= 1'b0;
      app_cmd         <= '0;
      app_addr        <= '0;
      app_wdf_wren    <= 1'b0;
      app_wdf_end     <= 1'b0;
      app_wdf_data    <= '0;
      app_wdf_mask    <= '1;
      core_resp_valid <= '0;
      core_resp_rdata <= '0;
    end else begin
      core_resp_valid <= '0;
      case (state_reg)
        ST_CALIB: begin
          if (init_calib_complete) state_reg <= ST_ARB;
        end

        ST_ARB: begin
          if (grant_valid) begin
            id_reg   <= grant_id;
            lane_reg <= sel_lane;
            app_addr <= sel_app_addr;
            app_en   <= 1'b1;
            if (core_req_wr[grant_id]) begin
              app_cmd      <= CMD_WRITE;
              app_wdf_wren <= 1'b1;
              app_wdf_end  <= 1'b1;
              app_wdf_data <= {LANES{req_wdata[grant_id]}};
              app_wdf_mask <= sel_mask;
              state_reg    <= ST_WRITE;
            end else begin
              app_cmd   <= CMD_READ;
              state_reg <= ST_READ_CMD;
            end
          end
        end

        ST_READ_CMD: begin
          if (app_rdy) begin
            app_en    <= 1'b0;
            state_reg <= ST_READ_WAIT;
          end
        end

        ST_READ_WAIT: begin
          if (app_rd_data_valid) begin
            core_resp_rdata <= app_rd_data[lane_reg*WORD_WIDTH +: WORD_WIDTH];
            core_resp_valid <= id_onehot;
            state_reg       <= ST_RESP;
          end
        end

        ST_WRITE: begin
          // Command and data strobes retire independently; leave once both
          // are done, which covers both finishing in the same cycle.
          if (app_en && app_rdy) app_en <= 1'b0;
          if (app_wdf_wren && app_wdf_rdy) begin
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
          end
          if ((!app_en || app_rdy) && (!app_wdf_wren || app_wdf_rdy)) begin
            core_resp_valid <= id_onehot;
            state_reg       <= ST_RESP;
          end
        end

        ST_RESP: begin
          state_reg <= ST_ARB;
        end

        default: state_reg <= ST_CALIB;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_ctrl.sv
// Directed testbench for core_mem_ctrl with hand-computed expectations.
module tb_core_mem_ctrl;

  localparam int NC = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          init_calib_complete;
  logic [NC-1:0] core_req_valid;
  logic [NC-1:0] core_req_wr;
  logic [NC*32-1:0] core_req_addr;
  logic [NC*32-1:0] core_req_wdata;
  logic [NC-1:0] core_resp_valid;
  logic [31:0]   core_resp_rdata;
  logic [27:0]   app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic          app_rdy;
  logic [127:0]  app_wdf_data;
  logic [15:0]   app_wdf_mask;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic          app_wdf_rdy;
  logic [127:0]  app_rd_data;
  logic          app_rd_data_valid;

  int checks   = 0;
  int failures = 0;

  core_mem_ctrl dut (
    .clk                 (clk),
    .reset               (reset),
    .init_calib_complete (init_calib_complete),
    .core_req_valid      (core_req_valid),
    .core_req_wr         (core_req_wr),
    .core_req_addr       (core_req_addr),
    .core_req_wdata      (core_req_wdata),
    .core_resp_valid     (core_resp_valid),
    .core_resp_rdata     (core_resp_rdata),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("txn %s got=%0h ok", tag, got);
    end
  endtask

  // Advance one clock; sample/drive 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int c, input logic wr, input logic [31:0] a, input logic [31:0] d);
    core_req_wr[c]            = wr;
    core_req_addr[c*32 +: 32] = a;
    core_req_wdata[c*32 +: 32] = d;
    core_req_valid[c]         = 1'b1;
  endtask

  task automatic wait_en(input int budget, input string tag);
    int n;
    n = 0;
    while (!app_en && n < budget) begin
      tick();
      n++;
    end
    check(tag, app_en, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_cnt;
    int n;
    int id;
    int exp_order [5];
    logic [NC-1:0] served;

    exp_order = '{1, 2, 15, 1, 2};

    reset = 1'b1;
    init_calib_complete = 1'b0;
    core_req_valid = '0;
    core_req_wr = '0;
    core_req_addr = '0;
    core_req_wdata = '0;
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    app_rd_data = '0;
    app_rd_data_valid = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_app_en", app_en, 0);
    check("rst_wren_end", {app_wdf_wren, app_wdf_end}, 0);
    check("rst_cmd_addr", {app_cmd, app_addr}, 0);
    check("rst_wdf_data", app_wdf_data, 0);
    check("rst_wdf_mask", app_wdf_mask, 16'hFFFF);
    check("rst_resp", {core_resp_valid, core_resp_rdata}, 0);

    // Calibration gating: core 0 read held off until calib completes
    reset = 1'b0;
    app_rdy = 1'b1;
    set_req(0, 1'b0, 32'h0, 32'h0);
    en_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (app_en) en_cnt++;
    end
    check("calib_gate_no_en", en_cnt, 0);
    init_calib_complete = 1'b1;
    wait_en(5, "calib_read_en");
    check("calib_read_cmd", app_cmd, 3'b001);
    en_cnt = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (app_en) en_cnt++;
    end
    check("calib_one_cmd", en_cnt, 1);
    app_rd_data = 128'h44444444_33333333_22222222_11111111;
    app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    check("calib_resp", core_resp_valid, 16'h0001);
    check("calib_rdata", core_resp_rdata, 32'h11111111);
    core_req_valid[0] = 1'b0;
    tick();
    check("calib_pulse_1cyc", core_resp_valid, 0);

    // Read with lane select: core 3, byte 0x18 -> lane 2
    set_req(3, 1'b0, 32'h0000_0018, 32'h0);
    wait_en(5, "lane_read_en");
    check("lane_app_addr", app_addr, 28'h8);
    check("lane_cmd", app_cmd, 3'b001);
    tick();
    check("lane_en_drop", app_en, 0);
    tick();
    tick();
    app_rd_data = 128'hcafecafe_faceface_babebabe_beadbead;
    app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    check("lane_resp", core_resp_valid, 16'h0008);
    check("lane_rdata", core_resp_rdata, 32'hfaceface);
    core_req_valid[3] = 1'b0;
    tick();

    // Masked write with stalls: core 5, 0x12345678 @ 0x4
    app_rdy = 1'b0;
    app_wdf_rdy = 1'b0;
    set_req(5, 1'b1, 32'h0000_0004, 32'h1234_5678);
    wait_en(5, "wr_en");
    check("wr_wren_end", {app_wdf_wren, app_wdf_end}, 2'b11);
    check("wr_cmd", app_cmd, 3'b000);
    check("wr_addr", app_addr, 28'h0);
    check("wr_mask", app_wdf_mask, 16'hFF0F);
    check("wr_data", app_wdf_data, 128'h12345678_12345678_12345678_12345678);
    tick();
    check("wr_w2_strobes", {app_en, app_wdf_wren, app_wdf_end}, 3'b111);
    app_wdf_rdy = 1'b1;
    tick();
    app_wdf_rdy = 1'b0;
    check("wr_w3_strobes", {app_en, app_wdf_wren, app_wdf_end}, 3'b100);
    check("wr_w3_noresp", core_resp_valid, 0);
    tick();
    check("wr_w4_strobes", {app_en, app_wdf_wren}, 2'b10);
    app_rdy = 1'b1;
    tick();
    check("wr_resp", core_resp_valid, 16'h0020);
    check("wr_en_drop", app_en, 0);
    core_req_valid[5] = 1'b0;
    app_rdy = 1'b0;
    tick();

    // Reset mid-read: core 7 at 0x40, reset during READ_WAIT
    app_rdy = 1'b1;
    set_req(7, 1'b0, 32'h0000_0040, 32'h0);
    wait_en(5, "rst_mid_en");
    check("rst_mid_addr", app_addr, 28'h20);
    tick();
    reset = 1'b1;
    init_calib_complete = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    app_rd_data = 128'hdddddddd_cccccccc_bbbbbbbb_aaaaaaaa;
    app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    check("rst_mid_noresp", core_resp_valid, 0);
    check("rst_mid_rdata", core_resp_rdata, 0);
    check("rst_mid_addr0", app_addr, 0);
    check("rst_mid_mask", app_wdf_mask, 16'hFFFF);
    en_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (app_en || core_resp_valid != 0) en_cnt++;
    end
    check("rst_mid_in_calib", en_cnt, 0);
    core_req_valid[7] = 1'b0;
    init_calib_complete = 1'b1;

    // Round-robin: cores 1, 2, 15 request continuously (writes, no stall)
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    set_req(1, 1'b1, 32'h100, 32'h1);
    set_req(2, 1'b1, 32'h200, 32'h2);
    set_req(15, 1'b1, 32'h300, 32'hF);
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (core_resp_valid == 0 && n < 20) begin
        tick();
        n++;
      end
      id = -1;
      for (int c = 0; c < NC; c++) if (core_resp_valid[c]) id = c;
      check($sformatf("rr_grant%0d", g), id, exp_order[g]);
      served = core_resp_valid;
      core_req_valid = core_req_valid & ~served;
      tick();
      core_req_valid = core_req_valid | served;
    end
    core_req_valid = '0;
    for (int i = 0; i < 5; i++) tick();

    // Simultaneous handshake: core 9, 0xC -> lane 3
    set_req(9, 1'b1, 32'h0000_000C, 32'hA5A5_5A5A);
    wait_en(5, "sim_en");
    check("sim_wren", {app_wdf_wren, app_wdf_end}, 2'b11);
    check("sim_mask", app_wdf_mask, 16'h0FFF);
    tick();
    check("sim_strobes_drop", {app_en, app_wdf_wren, app_wdf_end}, 3'b000);
    check("sim_resp", core_resp_valid, 16'h0200);
    core_req_valid[9] = 1'b0;
    tick();
    check("sim_pulse_1cyc", core_resp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
